cache_req_arbiter: RTL

Round-robin arbiter that shares the single cache operation port (controller plus memory block) among `NUM_REQ` independent requesters. It sits between the requester ports (bus interfaces, DMA-style clients) and the cache core.
- Accepts one request at a time, latches it, and issues it to the cache when the cache is not busy.
- Waits for completion, bounded by a timeout, and routes the hit, value and error result back to the granted requester only.

---
 rtl/cache_req_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache operation port among NUM_REQ requesters.
// Latches one request, issues it when the cache is free, waits for completion
// (bounded by a timeout) and returns the result to the granted port only.
module cache_req_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned KEY_WIDTH      = 16,
   parameter int unsigned VALUE_WIDTH    = 64,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned IdxW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int unsigned CntW          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   input  logic [2*NUM_REQ-1:0]           req_op_i,
   input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key_i,
   input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value_i,
   output logic [NUM_REQ-1:0]             rsp_valid_o,
   output logic                           rsp_hit_o,
   output logic [VALUE_WIDTH-1:0]         rsp_value_o,
   output logic                           rsp_err_o,
   output logic                           cache_start_o,
   output logic [1:0]                     cache_op_o,
   output logic [KEY_WIDTH-1:0]           cache_key_o,
   output logic [VALUE_WIDTH-1:0]         cache_value_o,
   input  logic                           cache_busy_i,
   input  logic                           cache_done_i,
   input  logic                           cache_hit_i,
   input  logic [VALUE_WIDTH-1:0]         cache_value_i,
   output logic [IdxW-1:0]                grant_idx_o
);

   localparam logic [1:0] OpNop = 2'b00;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e                 state_q, state_d;
   logic [IdxW-1:0]        ptr_q, ptr_d;
   logic [IdxW-1:0]        grant_q, grant_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [CntW-1:0]        cnt_inc;
   logic [1:0]             op_q, op_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [VALUE_WIDTH-1:0] val_q, val_d;
   logic                   hit_q, hit_d;
   logic                   err_q, err_d;
   logic [VALUE_WIDTH-1:0] rval_q, rval_d;

   logic                   found;
   logic [IdxW-1:0]        sel;
   logic [1:0]             sel_op;
   int                     idx;

   // Round-robin search: first valid port at or above ptr, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
         if (req_valid_i[idx]) begin
            found = 1'b1;
            sel   = IdxW'(idx);
         end
      end
   end

   assign sel_op  = req_op_i[2*sel +: 2];
   assign cnt_inc = cnt_q + CntW'(1);

   // Next-state logic and handshake/issue outputs.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      key_d         = key_q;
      val_d         = val_q;
      hit_d         = hit_q;
      err_d         = err_q;
      rval_d        = rval_q;
      req_ready_o   = '0;
      rsp_valid_o   = '0;
      cache_start_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Ready is gated by reset so every output reads 0 while it is held.
            if (found && !rst) begin
               req_ready_o[sel] = 1'b1;
               grant_d          = sel;
               op_d             = sel_op;
               key_d            = req_key_i[KEY_WIDTH*sel +: KEY_WIDTH];
               val_d            = req_value_i[VALUE_WIDTH*sel +: VALUE_WIDTH];
               if (sel_op == OpNop) begin
                  hit_d   = 1'b0;
                  err_d   = 1'b0;
                  rval_d  = '0;
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (!cache_busy_i) begin
               cache_start_o = 1'b1;
               cnt_d         = '0;
               state_d       = StWait;
            end
         end
         StWait: begin
            // Done is checked first so it wins on the timeout cycle.
            if (cache_done_i) begin
               hit_d   = cache_hit_i;
               rval_d  = cache_value_i;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
               hit_d   = 1'b0;
               rval_d  = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StResp: begin
            rsp_valid_o[grant_q] = 1'b1;
            ptr_d   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State, pointer, latched request and registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         key_q   <= '0;
         val_q   <= '0;
         hit_q   <= 1'b0;
         err_q   <= 1'b0;
         rval_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         key_q   <= key_d;
         val_q   <= val_d;
         hit_q   <= hit_d;
         err_q   <= err_d;
         rval_q  <= rval_d;
      end
   end

   assign cache_op_o    = op_q;
   assign cache_key_o   = key_q;
   assign cache_value_o = val_q;
   assign rsp_hit_o     = hit_q;
   assign rsp_err_o     = err_q;
   assign rsp_value_o   = rval_q;
   assign grant_idx_o   = grant_q;

endmodule
